// File: rtl/vga_pkg.sv
// Shared VGA timing constants, direction indices and the sprite motion FSM state type.
// Also holds the clamped single-axis step used by the motion scheduler.
package vga_pkg;

  localparam int HVA = 800;
  localparam int HFP = 40;
  localparam int HP  = 128;
  localparam int HBP = 88;
  localparam int VVA = 600;
  localparam int VFP = 1;
  localparam int VP  = 4;
  localparam int VBP = 23;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    UPDATE,
    COMMIT
  } motion_state_t;

  // Opposing requests cancel; the result never wraps below 0 or passes lim.
  function automatic logic [10:0] step_axis(
    input logic [10:0] p,
    input logic        dec,
    input logic        inc,
    input logic [11:0] step,
    input logic [11:0] lim
  );
    logic [11:0] w;
    w = {1'b0, p};
    if (dec && !inc) begin
      w = (w < step) ? 12'd0 : w - step;
    end else if (inc && !dec) begin
      w = ((w + step) > lim) ? lim : w + step;
    end
    return w[10:0];
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Bundle of frame timing, pixel position, direction requests and sprite status
// exchanged between the video pipeline and the sprite motion controller.
interface sprite_motion_ctrl_if;
  logic        en;
  logic        frame_start;
  logic        de;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [3:0]  dir_req;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        in_sprite;
  logic        busy;

  modport master (
    output en, frame_start, de, h_cnt, v_cnt, dir_req,
    input  pos_x, pos_y, in_sprite, busy
  );

  modport slave (
    input  en, frame_start, de, h_cnt, v_cnt, dir_req,
    output pos_x, pos_y, in_sprite, busy
  );
endinterface

// File: rtl/sprite_motion_ctrl_window.sv
// Registered box-hit test: flags pixels inside a SIZE x SIZE square whose
// top-left corner is (pos_x, pos_y). Reusable for any number of sprites.
module sprite_window #(
  parameter int SIZE = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        de,
  input  logic [10:0] h_cnt,
  input  logic [10:0] v_cnt,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  output logic        in_sprite
);

  logic        in_sprite_reg;
  logic        hit_next;
  logic [11:0] h_w, v_w, x_w, y_w;

  // Compare at 12 bits so pos + SIZE cannot overflow near the right edge.
  always_comb begin
    h_w      = {1'b0, h_cnt};
    v_w      = {1'b0, v_cnt};
    x_w      = {1'b0, pos_x};
    y_w      = {1'b0, pos_y};
    hit_next = en && de
               && (h_w >= x_w) && (h_w < x_w + 12'(SIZE))
               && (v_w >= y_w) && (v_w < y_w + 12'(SIZE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_sprite_reg <= 1'b0;
    end else begin
      in_sprite_reg <= hit_next;
    end
  end

  assign in_sprite = in_sprite_reg;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite mover: gathers direction requests during a frame and
// moves the sprite only at the start of vertical blanking, every HOLD frames.
module sprite_motion_ctrl #(
  parameter int HVA  = vga_pkg::HVA,
  parameter int VVA  = vga_pkg::VVA,
  parameter int SIZE = 32,
  parameter int STEP = 4,
  parameter int HOLD = 1,
  parameter int X0   = 384,
  parameter int Y0   = 284
) (
  input logic                 clk,
  input logic                 rst,
  sprite_motion_ctrl_if.slave bus
);
  import vga_pkg::*;

  motion_state_t state_reg, state_next;
  logic [7:0]    frame_cnt_reg, frame_cnt_next;
  logic [3:0]    req_reg, req_next;
  logic [3:0]    req_new_reg;
  logic [10:0]   nxt_x_reg, nxt_y_reg;
  logic [10:0]   pos_x_reg, pos_y_reg;
  logic [10:0]   step_x, step_y;

  assign step_x = step_axis(pos_x_reg, req_reg[DIR_LEFT], req_reg[DIR_RIGHT],
                            12'(STEP), 12'(HVA - SIZE));
  assign step_y = step_axis(pos_y_reg, req_reg[DIR_UP], req_reg[DIR_DOWN],
                            12'(STEP), 12'(VVA - SIZE));

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    req_next       = req_reg;
    if (!bus.en) begin
      state_next     = IDLE;
      frame_cnt_next = '0;
      req_next       = '0;
    end else begin
      case (state_reg)
        IDLE: state_next = WAIT_FRAME;
        WAIT_FRAME: begin
          req_next = req_reg | bus.dir_req;
          if (bus.frame_start) begin
            if (frame_cnt_reg == 8'(HOLD - 1)) begin
              state_next     = UPDATE;
              frame_cnt_next = '0;
            end else begin
              frame_cnt_next = frame_cnt_reg + 8'd1;
            end
          end
        end
        UPDATE: begin
          state_next = COMMIT;
          req_next   = req_reg | bus.dir_req;
        end
        // Latch restarts from requests seen after the snapshot was taken.
        COMMIT: begin
          state_next = WAIT_FRAME;
          req_next   = req_new_reg | bus.dir_req;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= '0;
      req_reg       <= '0;
      req_new_reg   <= '0;
      nxt_x_reg     <= 11'(X0);
      nxt_y_reg     <= 11'(Y0);
      pos_x_reg     <= 11'(X0);
      pos_y_reg     <= 11'(Y0);
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      req_reg       <= req_next;
      if (bus.en && state_reg == UPDATE) begin
        req_new_reg <= bus.dir_req;
        nxt_x_reg   <= step_x;
        nxt_y_reg   <= step_y;
      end
      if (bus.en && state_reg == COMMIT) begin
        pos_x_reg <= nxt_x_reg;
        pos_y_reg <= nxt_y_reg;
      end
    end
  end

  assign bus.pos_x = pos_x_reg;
  assign bus.pos_y = pos_y_reg;
  assign bus.busy  = (state_reg == UPDATE) || (state_reg == COMMIT);

  sprite_window #(.SIZE(SIZE)) u_window (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.en),
    .de        (bus.de),
    .h_cnt     (bus.h_cnt),
    .v_cnt     (bus.v_cnt),
    .pos_x     (pos_x_reg),
    .pos_y     (pos_y_reg),
    .in_sprite (bus.in_sprite)
  );

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Frame-synchronous motion scheduler for the moving sprite drawn by `vga_controller`. It latches direction requests during a frame, arbitrates them, and updates the sprite position only at the start of vertical blanking, so no visible frame tears. It also produces the registered `in_sprite` pixel flag that the colour mux uses to select the sprite colour.

## Interface
- `HVA`, 800, horizontal visible area in pixels
- `VVA`, 600, vertical visible area in lines
- `SIZE`, 32, sprite edge length in pixels
- `STEP`, 4, pixels moved per update
- `HOLD`, 1, frames per update (≥1)
- `X0`, 384, reset X position of the sprite's top-left corner
- `Y0`, 284, reset Y position of the sprite's top-left corner

- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous reset, active-low
- `en`  in  1  block enable
- `frame_start`  in  1  one-cycle pulse at the first blanking line after the visible area
- `de`  in  1  display enable (visible pixel)
- `h_cnt`  in  11  visible pixel column
- `v_cnt`  in  11  visible pixel line
- `dir_req`  in  4  direction requests, level or pulse: [0]=up, [1]=down, [2]=left, [3]=right
- `pos_x`  out  11  sprite X position
- `pos_y`  out  11  sprite Y position
- `in_sprite`  out  1  current pixel lies inside the sprite
- `busy`  out  1  position update in progress

## Operation
- **Reset:** `pos_x`=X0, `pos_y`=Y0, `in_sprite`=0, `busy`=0, request latch=0, frame counter=0, state=IDLE.
- **States:** IDLE, WAIT_FRAME, UPDATE, COMMIT.
  - IDLE→WAIT_FRAME when `en`=1.
  - WAIT_FRAME→UPDATE on `frame_start` when frame counter = HOLD-1. Any other `frame_start` only increments the counter.
  - UPDATE→COMMIT unconditionally.
  - COMMIT→WAIT_FRAME unconditionally.
- **Request latch:** `req_q |= dir_req` every cycle in WAIT_FRAME. A one-cycle pulse therefore counts. The latch is snapshotted in UPDATE and cleared on the COMMIT edge. Requests arriving in UPDATE or COMMIT are still ORed in after the clear.
- **Arbitration:** axes are independent.
  - up and down both set: no vertical move. left and right both set: no horizontal move.
  - One axis and another (e.g. up and right) set together: diagonal move.
- **Arithmetic:** computed at 12 bits unsigned, then clamped.
  - left: x = (x < STEP) ? 0 : x-STEP
  - right: x = min(x+STEP, HVA-SIZE)
  - Y is handled the same way, bounded by VVA-SIZE.
- **Register stages:** the next position is registered in UPDATE; `pos_x`/`pos_y` load on the COMMIT edge.
- **Sprite flag:** `in_sprite` = registered (`de` && `h_cnt` in [pos_x, pos_x+SIZE) && `v_cnt` in [pos_y, pos_y+SIZE)).
- **Disable:** `en`=0 in any state goes to IDLE next edge.
  - Clears the latch and frame counter.
  - Holds position.
  - Forces `in_sprite`=0 and `busy`=0.

## Timing
- `frame_start` sampled at edge k gives UPDATE after k and COMMIT after k+1. New `pos_x`/`pos_y` are valid after edge k+2. `busy`=1 exactly during UPDATE and COMMIT.
- `frame_start` while `busy`=1 is ignored and does not advance the counter.
- `in_sprite` latency is 1 cycle from `de`/`h_cnt`/`v_cnt`.
- Position cannot change during the visible area, provided `frame_start` marks blanking and blanking lasts more than 3 cycles.
- `rst` low mid-UPDATE or mid-COMMIT immediately restores all reset values; the partial update is discarded.

## Structure
- Shared package `vga_pkg` holds:
  - the timing constants HVA/HFP/HP/HBP/VVA/VFP/VP/VBP
  - direction index constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT
  - the state enum `motion_state_t`
- One sub-module, `sprite_window`: the registered box-hit comparator producing `in_sprite`. It is reusable for further sprites.

## Test plan
Defaults apply unless stated.
- **Reset/enable:** `rst`=0 → `pos`=(384,284), `in_sprite`=0, `busy`=0. Release reset, `en`=1 → state WAIT_FRAME, no movement without requests.
- **Move and hold:** `dir_req`=right held for 3 frame_starts → `pos_x`=396, `pos_y`=284. With HOLD=2 and 4 frame_starts → `pos_x`=392.
- **Clamp:**
  - X0=2, left → `pos_x`=0 (no wrap to 2046).
  - X0=766, right → `pos_x`=768.
  - Y0=566, down → `pos_y`=568.
- **Arbitration/latch:**
  - up+down held → `pos_y` unchanged.
  - up+right → (388,280).
  - Left pulsed 1 cycle mid-frame → `pos_x`=380 after the next frame_start, and unchanged after the following one.
- **Pixel flag:** `pos`=(384,284), `de`=1:
  - (384,284) → `in_sprite`=1 one cycle later.
  - (415,315) → 1.
  - (416,284) → 0.
  - `de`=0 → 0.
- **Disruptions:**
  - `rst` low during UPDATE → reset values, no position change.
  - `en`=0 during COMMIT → IDLE, position held, latch cleared.
  - `frame_start` while `busy` → ignored.
